// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file debug dump block.
package regfile_dump_pkg;

    localparam int unsigned NUM_ARCH_REGS = 16;
    localparam int unsigned IDX_W         = 4;
    localparam int unsigned BYTE_W        = 8;

    localparam logic [IDX_W-1:0] PC_INDEX = 4'hF;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_LOAD,
        ST_SEND_IDX,
        ST_SEND_DATA,
        ST_DONE
    } dump_state_e;

    // Index header byte: register number zero-extended to a byte.
    function automatic byte_t idx_byte(input logic [IDX_W-1:0] idx);
        return {4'h0, idx};
    endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// Register-file read port plus UART TX byte stream, bundled for the dump master.
interface regfile_dump_if #(
    parameter int unsigned DATA_W = 32
);
    import regfile_dump_pkg::*;

    logic [IDX_W-1:0]  ra;
    logic [DATA_W-1:0] rd;
    byte_t             tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output ra,
        output tx_data,
        output tx_valid,
        input  rd,
        input  tx_ready
    );

    modport slave (
        input  ra,
        input  tx_data,
        input  tx_valid,
        output rd,
        output tx_ready
    );

endinterface

// File: rtl/regfile_dump_shifter.sv
// Loadable big-endian word-to-byte shifter; MSB byte is always presented first.
module regfile_dump_shifter
    import regfile_dump_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_data,
    output byte_t             o_byte,
    output byte_t             o_next_byte_c,
    output logic              o_last_c
);

    localparam int unsigned BYTES_PER_REG = DATA_W / BYTE_W;
    localparam int unsigned CNT_W         = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [DATA_W-1:0] w_shifted;

    assign w_shifted = r_shift << BYTE_W;

    // Load wins over shift; the counter restarts with every new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (i_load) begin
            r_shift    <= i_data;
            r_byte_cnt <= '0;
        end else if (i_shift) begin
            r_shift    <= w_shifted;
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
    end

    assign o_byte        = r_shift[DATA_W-1 -: BYTE_W];
    assign o_next_byte_c = w_shifted[DATA_W-1 -: BYTE_W];
    assign o_last_c      = (r_byte_cnt == CNT_W'(BYTES_PER_REG - 1));

endmodule

// File: rtl/regfile_dump.sv
// Debug dump master: halts the CPU, walks the register file and streams
// {index byte, data bytes MSB-first} for every register to the UART TX.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_ARCH_REGS,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dump_start,
    output logic                   busy,
    output logic                   done,
    output logic                   halt_req,
    input  logic                   halt_ack,
    regfile_dump_if.master         bus
);

    localparam logic [IDX_W-1:0] LAST_IDX =
        (NUM_REGS == NUM_ARCH_REGS) ? PC_INDEX : IDX_W'(NUM_REGS - 1);

    dump_state_e      r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_ra;
    logic             r_busy;
    logic             r_done;
    logic             r_halt_req;
    logic             r_tx_valid;
    byte_t            r_tx_data;

    logic             w_hs;
    logic             w_load;
    logic             w_shift;
    byte_t            w_msb_byte;
    byte_t            w_next_byte;
    logic             w_last_byte;

    assign w_hs    = r_tx_valid && bus.tx_ready;
    assign w_load  = (r_state == ST_LOAD);
    assign w_shift = (r_state == ST_SEND_DATA) && w_hs;

    regfile_dump_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_load),
        .i_shift       (w_shift),
        .i_data        (bus.rd),
        .o_byte        (w_msb_byte),
        .o_next_byte_c (w_next_byte),
        .o_last_c      (w_last_byte)
    );

    // Sequencer; tx_data is pre-loaded with the next byte at each handshake
    // so back-to-back bytes go out without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_ra       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_halt_req <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (dump_start) begin
                        r_state    <= ST_HALT;
                        r_busy     <= 1'b1;
                        r_halt_req <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (halt_ack) begin
                        r_state <= ST_LOAD;
                        r_ra    <= r_idx;
                    end
                end
                ST_LOAD: begin
                    r_state    <= ST_SEND_IDX;
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= idx_byte(r_idx);
                end
                ST_SEND_IDX: begin
                    if (w_hs) begin
                        r_state   <= ST_SEND_DATA;
                        r_tx_data <= w_msb_byte;
                    end
                end
                ST_SEND_DATA: begin
                    if (w_hs) begin
                        if (w_last_byte) begin
                            r_tx_valid <= 1'b0;
                            if (r_idx == LAST_IDX) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_LOAD;
                                r_idx   <= r_idx + IDX_W'(1);
                                r_ra    <= r_idx + IDX_W'(1);
                            end
                        end else begin
                            r_tx_data <= w_next_byte;
                        end
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_halt_req <= 1'b0;
                    r_idx      <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign halt_req     = r_halt_req;
    assign bus.ra       = r_ra;
    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_data  = r_tx_data;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: scenario table, reference stream model,
// handshake stability monitor and a mid-dump reset sequence.
module tb_regfile_dump;
    import regfile_dump_pkg::*;

    localparam int NREG   = 16;
    localparam int DW     = 32;
    localparam int NBYTES = NREG * (1 + DW / 8);

    logic clk = 1'b0;
    logic rst_n;
    logic dump_start;
    logic halt_ack;
    logic busy;
    logic done;
    logic halt_req;

    always #5 clk = ~clk;

    regfile_dump_if #(.DATA_W(DW)) bus ();

    regfile_dump #(
        .NUM_REGS (NREG),
        .DATA_W   (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dump_start (dump_start),
        .busy       (busy),
        .done       (done),
        .halt_req   (halt_req),
        .halt_ack   (halt_ack),
        .bus        (bus)
    );

    // CPU register file model: combinational read, writes blocked while stalled.
    logic [31:0] regs [NREG];
    logic [31:0] snap [NREG];
    assign bus.rd = regs[bus.ra];

    byte_t cap[$];
    byte_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    done_cnt = 0;
    logic  stall_prev = 1'b0;
    byte_t prev_data;

    typedef struct {
        bit pattern;
        int ready_pct;
        int ack_delay;
        bit spam;
        bit writes;
        int exp_bytes;
        int exp_done;
        int exp_lat;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cpu_write(input int a, input logic [31:0] d);
        if (!halt_ack) regs[a] = d;
    endtask

    task automatic load_regs(input bit pattern);
        for (int i = 0; i < NREG; i++)
            regs[i] = pattern ? (32'h1000_0000 + 32'(i)) : $urandom;
        if (pattern) regs[NREG-1] = 32'h0000_0040;
    endtask

    // Reference stream: per register its index, then the word MSB byte first.
    task automatic build_expected();
        exp_q.delete();
        for (int r = 0; r < NREG; r++) begin
            exp_q.push_back(byte_t'(r));
            for (int b = DW / 8 - 1; b >= 0; b--)
                exp_q.push_back(byte_t'(snap[r] >> (8 * b)));
        end
    endtask

    // Byte capture, done counting and tx stability while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hs_valid_held", 64'(bus.tx_valid), 64'(1));
                check("hs_data_held", 64'(bus.tx_data), 64'(prev_data));
            end
            if (bus.tx_valid && bus.tx_ready) cap.push_back(bus.tx_data);
            if (done) done_cnt++;
            stall_prev = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
        end
    end

    task automatic run_dump(input vec_t v, input int vi);
        int seen_done, post, wait_cnt, quiet_bad, first_valid, ack_cyc, lat, mism;
        logic end_busy, end_halt;
        logic [39:0] head, tail;
        logic [31:0] r3;
        cap.delete();
        done_cnt = 0;
        load_regs(v.pattern);
        for (int i = 0; i < NREG; i++) snap[i] = regs[i];
        build_expected();
        halt_ack       = (v.ack_delay == 0);
        bus.tx_ready   = 1'b0;
        dump_start     = 1'b0;
        seen_done      = 0;
        post           = 0;
        wait_cnt       = 0;
        quiet_bad      = 0;
        first_valid    = -1;
        ack_cyc        = 0;
        end_busy       = 1'b1;
        end_halt       = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            if (first_valid < 0 && bus.tx_valid) first_valid = cyc;
            if (halt_req && !halt_ack) begin
                wait_cnt++;
                if (!busy || bus.tx_valid) quiet_bad++;
            end
            if (done) seen_done = 1;
            if (seen_done != 0) post++;
            if (post == 3) begin
                end_busy = busy;
                end_halt = halt_req;
                break;
            end
            dump_start = (cyc == 0) || (v.spam && seen_done == 0);
            if (!halt_ack && halt_req && wait_cnt >= v.ack_delay) begin
                halt_ack = 1'b1;
                ack_cyc  = cyc;
            end
            bus.tx_ready = (int'($urandom_range(99)) < v.ready_pct);
            if (v.writes && halt_ack) cpu_write(int'($urandom_range(NREG - 1)), 32'hDEAD_BEEF);
        end
        dump_start   = 1'b0;
        halt_ack     = 1'b0;
        bus.tx_ready = 1'b0;

        check($sformatf("v%0d_done_seen", vi), 64'(seen_done), 64'(1));
        check($sformatf("v%0d_byte_count", vi), 64'(cap.size()), 64'(v.exp_bytes));
        mism = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (k >= cap.size() || cap[k] !== exp_q[k]) mism++;
        check($sformatf("v%0d_stream_mismatches", vi), 64'(mism), 64'(0));
        check($sformatf("v%0d_done_pulses", vi), 64'(done_cnt), 64'(v.exp_done));
        check($sformatf("v%0d_busy_after", vi), 64'(end_busy), 64'(0));
        check($sformatf("v%0d_halt_req_after", vi), 64'(end_halt), 64'(0));
        lat = (v.ack_delay == 0) ? first_valid : first_valid - ack_cyc;
        check($sformatf("v%0d_first_byte_latency", vi), 64'(lat), 64'(v.exp_lat));
        if (v.ack_delay > 0) begin
            check($sformatf("v%0d_halt_wait_quiet", vi), 64'(quiet_bad), 64'(0));
            check($sformatf("v%0d_halt_wait_cycles", vi), 64'(wait_cnt), 64'(v.ack_delay));
        end
        if (v.pattern && cap.size() >= NBYTES) begin
            head = '0;
            tail = '0;
            for (int k = 0; k < 5; k++) head = {head[31:0], cap[k]};
            for (int k = NBYTES - 5; k < NBYTES; k++) tail = {tail[31:0], cap[k]};
            check($sformatf("v%0d_first_5_bytes", vi), 64'(head), 64'(40'h00_10_00_00_00));
            check($sformatf("v%0d_last_5_bytes", vi), 64'(tail), 64'(40'h0F_00_00_00_40));
            if (v.writes) begin
                r3 = '0;
                for (int k = 16; k < 20; k++) r3 = {r3[23:0], cap[k]};
                check($sformatf("v%0d_r3_snapshot", vi), 64'(r3), 64'(32'h1000_0003));
            end
        end
    endtask

    initial begin
        vec_t rv;
        int   got;
        // pattern, ready%, ack delay, spam start, writes, bytes, done, latency
        vecs[0] = '{1'b1, 100,  0, 1'b0, 1'b0, NBYTES, 1, 3};
        vecs[1] = '{1'b0,  30,  0, 1'b0, 1'b0, NBYTES, 1, 3};
        vecs[2] = '{1'b1, 100, 50, 1'b0, 1'b0, NBYTES, 1, 2};
        vecs[3] = '{1'b0,  70,  0, 1'b1, 1'b0, NBYTES, 1, 3};
        vecs[4] = '{1'b1,  50,  3, 1'b0, 1'b1, NBYTES, 1, 2};
        vecs[5] = '{1'b0, 100,  5, 1'b1, 1'b1, NBYTES, 1, 2};

        rst_n        = 1'b0;
        dump_start   = 1'b0;
        halt_ack     = 1'b0;
        bus.tx_ready = 1'b0;
        load_regs(1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_halt_req", 64'(halt_req), 64'(0));
        check("rst_ra", 64'(bus.ra), 64'(0));
        check("rst_tx_valid", 64'(bus.tx_valid), 64'(0));
        check("rst_tx_data", 64'(bus.tx_data), 64'(0));
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_halt_req", 64'(halt_req), 64'(0));

        for (int vi = 0; vi < 6; vi++) run_dump(vecs[vi], vi);

        // Reset while streaming the data bytes of register 7.
        load_regs(1'b1);
        cap.delete();
        halt_ack     = 1'b1;
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1 dump_start = 1'b1;
        @(posedge clk);
        #1 dump_start = 1'b0;
        got = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (cap.size() >= 37) begin
                got = 1;
                break;
            end
        end
        check("midrst_reached_r7", 64'(got), 64'(1));
        check("midrst_pre_ra", 64'(bus.ra), 64'(7));
        check("midrst_pre_valid", 64'(bus.tx_valid), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_halt_req", 64'(halt_req), 64'(0));
        check("midrst_ra", 64'(bus.ra), 64'(0));
        check("midrst_tx_valid", 64'(bus.tx_valid), 64'(0));
        check("midrst_tx_data", 64'(bus.tx_data), 64'(0));
        halt_ack     = 1'b0;
        bus.tx_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rv = '{1'b1, 100, 0, 1'b0, 1'b0, NBYTES, 1, 3};
        run_dump(rv, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
